// File: rtl/mem_map_pkg.sv
// mem_map_pkg: address map constants, FSM states and segment decode for mem_periph_ctrl.
package mem_map_pkg;
  localparam logic [31:0] TEXT_BASE = 32'h0000_0000;
  localparam logic [31:0] TEXT_END  = 32'h0FFF_FFFF;
  localparam logic [31:0] DATA_BASE = 32'h1000_0000;
  localparam logic [31:0] DATA_END  = 32'h7FFF_FFFF;
  localparam logic [31:0] IO_BASE   = 32'hFFFF_0000;
  typedef enum logic [2:0] {IDLE, DECODE, MEM, IO_WAIT, RESP} state_t;
  typedef enum logic [1:0] {SEG_TEXT, SEG_DATA, SEG_IO, SEG_NONE} seg_t;
  // The IO segment runs to the top of the address space, so it has no upper bound to test.
  function automatic seg_t seg_of(input logic [31:0] a);
    return a <= TEXT_END ? SEG_TEXT :
           (a >= DATA_BASE && a <= DATA_END) ? SEG_DATA :
           a >= IO_BASE ? SEG_IO : SEG_NONE;
  endfunction
endpackage

// File: rtl/mem_periph_ctrl_if.sv
// mem_periph_ctrl_if: virtual-address request/response bus plus peripheral channel bus.
interface mem_periph_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int NUM_IO = 4
);
  logic                     reqVirt;
  logic [31:0]              addressVirt;
  logic [DATA_W-1:0]        dataInVirt;
  logic                     wEnVirt;
  logic                     readyVirt;
  logic                     respVirt;
  logic [DATA_W-1:0]        dataOutVirt;
  logic                     errVirt;
  logic [NUM_IO-1:0]        ioSel;
  logic                     ioWEn;
  logic [7:0]               ioAddr;
  logic [DATA_W-1:0]        ioWData;
  logic [NUM_IO*DATA_W-1:0] ioRData;
  logic [NUM_IO-1:0]        ioAck;
  modport slave (
    input  reqVirt, addressVirt, dataInVirt, wEnVirt, ioRData, ioAck,
    output readyVirt, respVirt, dataOutVirt, errVirt, ioSel, ioWEn, ioAddr, ioWData
  );
  modport master (
    output reqVirt, addressVirt, dataInVirt, wEnVirt, ioRData, ioAck,
    input  readyVirt, respVirt, dataOutVirt, errVirt, ioSel, ioWEn, ioAddr, ioWData
  );
endinterface

// File: rtl/sp_ram.sv
// sp_ram: single-port RAM with synchronous read; contents are not reset.
module sp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_periph_ctrl.sv
// mem_periph_ctrl: decodes virtual accesses to text RAM, data RAM or IO channels.
// Define TEXT_WP_EN to make the text segment write-protected.
module mem_periph_ctrl
  import mem_map_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int TEXT_WORDS = 256,
  parameter int DATA_WORDS = 256,
  parameter int NUM_IO     = 4,
  parameter int IO_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rstVirt,
  mem_periph_ctrl_if.slave bus
);
  localparam int TAW = $clog2(TEXT_WORDS);
  localparam int DAW = $clog2(DATA_WORDS);
  localparam int CW  = $clog2(IO_TIMEOUT + 1);
`ifdef TEXT_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  state_t            state;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wen_q;
  logic [CW-1:0]     cnt;
  seg_t              seg;
  logic [3:0]        ch;
  logic              ch_ok;
  logic              ram_ok;
  logic              io_hit;
  logic [DATA_W-1:0] text_rdata;
  logic [DATA_W-1:0] data_rdata;
  logic [DATA_W-1:0] io_rdata;
  assign seg    = seg_of(addr_q);
  assign ch     = addr_q[11:8];
  assign ch_ok  = int'(ch) < NUM_IO;
  assign ram_ok = seg == SEG_DATA || (seg == SEG_TEXT && !(WP && wen_q));
  assign io_hit = |(bus.ioAck & bus.ioSel);
  assign io_rdata = bus.ioRData[int'(ch) * DATA_W +: DATA_W];
  // RAM address comes from the latched request, so read data is ready by the MEM cycle.
  sp_ram #(.WIDTH(DATA_W), .DEPTH(TEXT_WORDS)) u_text (
    .clk(clk),
    .we(state == MEM && seg == SEG_TEXT && wen_q),
    .addr(TAW'((addr_q - TEXT_BASE) >> 2)),
    .wdata(data_q),
    .rdata(text_rdata)
  );
  sp_ram #(.WIDTH(DATA_W), .DEPTH(DATA_WORDS)) u_data (
    .clk(clk),
    .we(state == MEM && seg == SEG_DATA && wen_q),
    .addr(DAW'((addr_q - DATA_BASE) >> 2)),
    .wdata(data_q),
    .rdata(data_rdata)
  );
  always_ff @(posedge clk or negedge rstVirt) begin
    if (!rstVirt) begin
      state           <= IDLE;
      addr_q          <= '0;
      data_q          <= '0;
      wen_q           <= 1'b0;
      cnt             <= '0;
      bus.readyVirt   <= 1'b1;
      bus.respVirt    <= 1'b0;
      bus.errVirt     <= 1'b0;
      bus.dataOutVirt <= '0;
      bus.ioSel       <= '0;
      bus.ioWEn       <= 1'b0;
      bus.ioAddr      <= '0;
      bus.ioWData     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.reqVirt) begin
          addr_q        <= bus.addressVirt;
          data_q        <= bus.dataInVirt;
          wen_q         <= bus.wEnVirt;
          bus.readyVirt <= 1'b0;
          state         <= DECODE;
        end
        DECODE: if (ram_ok) begin
          state <= MEM;
        end else if (seg == SEG_IO && ch_ok) begin
          bus.ioSel   <= NUM_IO'(1) << ch;
          bus.ioAddr  <= addr_q[7:0];
          bus.ioWData <= data_q;
          bus.ioWEn   <= wen_q;
          cnt         <= '0;
          state       <= IO_WAIT;
        end else begin
          bus.respVirt    <= 1'b1;
          bus.errVirt     <= 1'b1;
          bus.dataOutVirt <= '0;
          state           <= RESP;
        end
        MEM: begin
          bus.respVirt    <= 1'b1;
          bus.dataOutVirt <= wen_q ? '0 : seg == SEG_TEXT ? text_rdata : data_rdata;
          state           <= RESP;
        end
        // An ack on the last allowed cycle still wins over the timeout.
        IO_WAIT: if (io_hit || cnt == CW'(IO_TIMEOUT - 1)) begin
          bus.respVirt    <= 1'b1;
          bus.errVirt     <= !io_hit;
          bus.dataOutVirt <= (io_hit && !wen_q) ? io_rdata : '0;
          bus.ioSel       <= '0;
          bus.ioWEn       <= 1'b0;
          cnt             <= '0;
          state           <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: begin
          bus.respVirt    <= 1'b0;
          bus.errVirt     <= 1'b0;
          bus.dataOutVirt <= '0;
          bus.readyVirt   <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_periph_ctrl.md
MEM_PERIPH_CTRL -- requirements
Module: mem_periph_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits.
REQ-002 Parameter TEXT_WORDS, default 256, text RAM depth in words; must be a power of two.
REQ-003 Parameter DATA_WORDS, default 256, data RAM depth in words; must be a power of two.
REQ-004 Parameter NUM_IO, default 4, peripheral channel count, range 1..16.
REQ-005 Parameter IO_TIMEOUT, default 15, maximum cycles spent waiting for a peripheral ack.
REQ-006 clk  input  1  single clock; all logic is rising-edge.
REQ-007 rstVirt  input  1  asynchronous, active-low reset.
REQ-008 reqVirt  input  1  request valid.
REQ-009 addressVirt  input  32  virtual byte address.
REQ-010 dataInVirt  input  DATA_W  write data.
REQ-011 wEnVirt  input  1  1 = write, 0 = read.
REQ-012 readyVirt  output  1  high only in IDLE; a request is accepted when reqVirt and readyVirt are both high on a rising edge.
REQ-013 respVirt  output  1  one-cycle response strobe.
REQ-014 dataOutVirt  output  DATA_W  read data; valid while respVirt is high.
REQ-015 errVirt  output  1  error flag; valid while respVirt is high.
REQ-016 ioSel  output  NUM_IO  one-hot channel select.
REQ-017 ioWEn  output  1  peripheral write strobe.
REQ-018 ioAddr  output  8  peripheral register offset.
REQ-019 ioWData  output  DATA_W  peripheral write data.
REQ-020 ioRData  input  NUM_IO*DATA_W  per-channel read data.
REQ-021 ioAck  input  NUM_IO  per-channel completion.

Function
REQ-022 Address decode SHALL be: text 0x0000_0000-0x0FFF_FFFF; data 0x1000_0000-0x7FFF_FFFF; IO 0xFFFF_0000-0xFFFF_FFFF; everything else is unmapped.
REQ-023 RAM word index SHALL be (address - segment base)[.. :2] modulo depth, so out-of-depth addresses wrap around.
REQ-024 IO channel SHALL be address[11:8] and register offset address[7:0]; a channel number >= NUM_IO is unmapped.
REQ-025 The FSM SHALL have states IDLE, DECODE, MEM, IO_WAIT and RESP.
REQ-026 On accept, the FSM SHALL move IDLE->DECODE and latch address, data and wEnVirt; later changes on the inputs are ignored.
REQ-027 From DECODE, RAM accesses SHALL go to MEM, IO accesses to IO_WAIT, and unmapped accesses to RESP with errVirt=1.
REQ-028 MEM SHALL last one cycle, commit a write or perform a synchronous read, then go to RESP; a request accepted at edge N responds in cycle N+3.
REQ-029 In IO_WAIT, ioSel, ioAddr, ioWData and ioWEn SHALL be held until the selected channel's ioAck; ack -> RESP with dataOutVirt = that channel's ioRData.
REQ-030 After IO_TIMEOUT cycles in IO_WAIT without an ack, the FSM SHALL go to RESP with errVirt=1 and dataOutVirt=0.
REQ-031 RESP SHALL assert respVirt for exactly one cycle and then return to IDLE.
REQ-032 On writes, and on every error, dataOutVirt SHALL be 0.
REQ-033 ioAck on a non-selected channel SHALL be ignored.

Reset
REQ-034 When rstVirt=0: FSM to IDLE, readyVirt=1, respVirt=0, errVirt=0, dataOutVirt=0, ioSel=0, ioWEn=0, timeout counter 0; RAM contents are undefined.
REQ-035 Reset asserted mid-operation SHALL abort the operation with no response; a RAM write is committed only if MEM completed before the reset.

Configuration
REQ-036 With TEXT_WP_EN defined, a write to the text segment SHALL give RESP with errVirt=1 and leave the RAM unchanged.
REQ-037 Without TEXT_WP_EN, text writes SHALL behave like data writes.

Structure
REQ-038 Package mem_map_pkg SHALL hold the segment base/end constants, the FSM state enum and the segment-type enum.
REQ-039 Each RAM SHALL be an instance of a single sub-module sp_ram (parametrised depth/width, synchronous read).

Verification
REQ-040 Write 0xA5A5A5A5 to 0x0000_0000, then read it -> respVirt at cycle N+3 with 0xA5A5A5A5, errVirt=0.
REQ-041 Write 0x12345678 to 0x1000_0400 with DATA_WORDS=256; read 0x1000_0000 -> 0x12345678 (wrap-around).
REQ-042 Read 0xFFFF_0104, channel 1 acks after 3 cycles with 0xDEADBEEF -> ioSel=4'b0010, ioAddr=0x04, dataOutVirt=0xDEADBEEF.
REQ-043 Read 0xFFFF_0200, no ack -> respVirt with errVirt=1 after IO_TIMEOUT cycles; accesses to 0x8000_0000 and 0xFFFF_0F00 -> errVirt=1.
REQ-044 Under TEXT_WP_EN, write 0x5A5A5A5A to 0x0000_0000 -> errVirt=1 and a read-back returns the old value.
REQ-045 rstVirt low during IO_WAIT -> respVirt never asserts, readyVirt=1 immediately, ioSel=0.
